// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared I2C bit values and read-sequencer state encoding
package i2c_pkg;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_SPACE,
        ST_READ,
        ST_ACK,
        ST_DONE
    } state_t;

endpackage

// File: rtl/i2c_byte_fifo.sv
// rtl/i2c_byte_fifo.sv - byte FIFO with first-word-fall-through head
module i2c_byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] head,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A push at full is only accepted when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/i2c_master_read_sequencer.sv
// rtl/i2c_master_read_sequencer.sv - multi-byte I2C master read with ACK/NACK and output FIFO
module i2c_master_read_sequencer
    import i2c_pkg::*;
#(
    parameter int LEN_W      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [LEN_W-1:0] length,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             rd_go,
    input  logic             rd_finish,
    input  logic             rd_data,
    input  logic             rd_load,
    output logic             ack_go,
    output logic             ack_bit,
    input  logic             ack_finish,
    output logic [7:0]       out_byte,
    output logic             out_valid,
    input  logic             out_ready
);

    state_t           state;
    state_t           state_next;
    logic [7:0]       shift;
    logic [3:0]       bitcnt;
    logic [LEN_W-1:0] remaining;
    logic             err_len;

    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic [7:0]       push_data;

    // The final bit may arrive in the same cycle as rd_finish.
    assign push      = (state == ST_READ) && rd_finish && !abort;
    assign push_data = rd_load ? {shift[6:0], rd_data} : shift;
    assign out_valid = !fifo_empty;

    i2c_byte_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (push_data),
        .pop       (out_ready),
        .head      (out_byte),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = (state != ST_IDLE);
        done       = (state == ST_DONE);
        rd_go      = (state == ST_READ);
        ack_go     = (state == ST_ACK);
        ack_bit    = I2C_ACK;
        if ((state == ST_ACK) && (remaining == '0)) begin
            ack_bit = I2C_NACK;
        end
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = (length != '0) ? ST_WAIT_SPACE : ST_DONE;
                end
            end
            ST_WAIT_SPACE: begin
                if (abort)           state_next = ST_DONE;
                else if (!fifo_full) state_next = ST_READ;
            end
            ST_READ: begin
                if (abort)          state_next = ST_DONE;
                else if (rd_finish) state_next = ST_ACK;
            end
            ST_ACK: begin
                if (abort) begin
                    state_next = ST_DONE;
                end else if (ack_finish) begin
                    state_next = (remaining != '0) ? ST_WAIT_SPACE : ST_DONE;
                end
            end
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shift     <= '0;
            bitcnt    <= '0;
            remaining <= '0;
            err_len   <= 1'b0;
        end else begin
            if ((state == ST_IDLE) && start && (length != '0)) begin
                remaining <= length;
            end
            if (state == ST_READ) begin
                if (abort) begin
                    shift  <= '0;
                    bitcnt <= '0;
                end else if (rd_finish) begin
                    remaining <= remaining - 1'b1;
                    shift     <= '0;
                    bitcnt    <= '0;
                    if ((bitcnt + {3'b000, rd_load}) != 4'd8) begin
                        err_len <= 1'b1;
                    end
                end else if (rd_load) begin
                    shift  <= {shift[6:0], rd_data};
                    bitcnt <= bitcnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2c_master_read_sequencer.sv
// tb/tb_i2c_master_read_sequencer.sv - directed bench for the I2C master read sequencer
module tb_i2c_master_read_sequencer;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] length = '0;
    logic       abort = 1'b0;
    logic       busy, done, rd_go, ack_go, ack_bit, out_valid;
    logic       rd_finish = 1'b0;
    logic       rd_data = 1'b0;
    logic       rd_load = 1'b0;
    logic       ack_finish = 1'b0;
    logic [7:0] out_byte;
    logic       out_ready = 1'b0;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] popped[$];
    logic       ack_bits[$];
    int         done_cnt = 0;
    bit         saw_rd = 0;
    bit         saw_ack = 0;

    i2c_master_read_sequencer #(.LEN_W(8), .FIFO_DEPTH(4)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .length     (length),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .rd_go      (rd_go),
        .rd_finish  (rd_finish),
        .rd_data    (rd_data),
        .rd_load    (rd_load),
        .ack_go     (ack_go),
        .ack_bit    (ack_bit),
        .ack_finish (ack_finish),
        .out_byte   (out_byte),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (reset_n) begin
            if (out_valid && out_ready) popped.push_back(out_byte);
            if (ack_go && ack_finish)   ack_bits.push_back(ack_bit);
            if (done)                   done_cnt++;
            if (rd_go)                  saw_rd = 1;
            if (ack_go)                 saw_ack = 1;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_start(input logic [7:0] len);
        tick();
        start  = 1'b1;
        length = len;
        tick();
        start  = 1'b0;
    endtask

    task automatic serve_bits(input logic [7:0] b, input int nbits, input bit coincident,
                              input bit pop_at_finish, output bit ok);
        ok = 0;
        for (int w = 0; w < 200 && !ok; w++) begin
            @(negedge clock);
            if (rd_go) ok = 1;
        end
        if (!ok) return;
        for (int i = 0; i < nbits; i++) begin
            tick();
            rd_load   = 1'b1;
            rd_data   = b[nbits-1-i];
            rd_finish = coincident && (i == nbits - 1);
            if (rd_finish && pop_at_finish) out_ready = 1'b1;
        end
        if (!coincident) begin
            tick();
            rd_load   = 1'b0;
            rd_finish = 1'b1;
            if (pop_at_finish) out_ready = 1'b1;
        end
        tick();
        rd_load   = 1'b0;
        rd_finish = 1'b0;
        rd_data   = 1'b0;
        if (pop_at_finish) out_ready = 1'b0;
    endtask

    task automatic serve_ack(output bit ok);
        ok = 0;
        for (int w = 0; w < 200 && !ok; w++) begin
            @(negedge clock);
            if (ack_go) ok = 1;
        end
        if (!ok) return;
        tick();
        ack_finish = 1'b1;
        tick();
        ack_finish = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 0;
        for (int w = 0; w < 200 && !ok; w++) begin
            @(negedge clock);
            if (done) ok = 1;
        end
    endtask

    task automatic test_reset();
        repeat (2) tick();
        n_checks++;
        if ({busy, done, rd_go, ack_go, ack_bit, out_valid, out_byte} !== 14'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %0h expected 0",
                     {busy, done, rd_go, ack_go, ack_bit, out_valid, out_byte});
        end
        reset_n = 1'b1;
        tick();
        n_checks++;
        if ({busy, out_valid, dut.u_fifo.count} !== 5'h0) begin
            n_fail++;
            $display("FAIL reset_release: got %0h expected 0", {busy, out_valid, dut.u_fifo.count});
        end
    endtask

    task automatic test_three_bytes();
        logic [7:0] b [3] = '{8'hA5, 8'h3C, 8'hFF};
        logic       a [3] = '{1'b0, 1'b0, 1'b1};
        bit ok;
        popped.delete(); ack_bits.delete(); done_cnt = 0; out_ready = 1'b1;
        do_start(8'd3);
        for (int k = 0; k < 3; k++) begin
            serve_bits(b[k], 8, 1, 0, ok);
            n_checks++;
            if (!ok) begin n_fail++; $display("FAIL three_rd_go[%0d]: got timeout expected rd_go", k); end
            serve_ack(ok);
            n_checks++;
            if (!ok) begin n_fail++; $display("FAIL three_ack_go[%0d]: got timeout expected ack_go", k); end
        end
        wait_done(ok);
        tick();
        n_checks++;
        if (!ok || busy !== 1'b0 || done_cnt !== 1) begin
            n_fail++;
            $display("FAIL three_done: got ok=%0d busy=%0b dones=%0d expected 1 0 1", ok, busy, done_cnt);
        end
        n_checks++;
        if (popped.size() !== 3 || ack_bits.size() !== 3) begin
            n_fail++;
            $display("FAIL three_counts: got bytes=%0d acks=%0d expected 3 3", popped.size(), ack_bits.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (popped[k] !== b[k] || ack_bits[k] !== a[k]) begin
                    n_fail++;
                    $display("FAIL three_byte[%0d]: got %0h/%0b expected %0h/%0b",
                             k, popped[k], ack_bits[k], b[k], a[k]);
                end
            end
        end
        n_checks++;
        if (dut.err_len !== 1'b0) begin
            n_fail++;
            $display("FAIL three_err_len: got %0b expected 0", dut.err_len);
        end
    endtask

    task automatic test_zero_length();
        saw_rd = 0; saw_ack = 0; done_cnt = 0;
        do_start(8'd0);
        n_checks++;
        if (done !== 1'b1) begin n_fail++; $display("FAIL zero_done: got %0b expected 1", done); end
        tick();
        n_checks++;
        if ({done, busy, saw_rd, saw_ack} !== 4'b0000 || done_cnt !== 1) begin
            n_fail++;
            $display("FAIL zero_after: got done=%0b busy=%0b rd=%0b ack=%0b dones=%0d expected 0 0 0 0 1",
                     done, busy, saw_rd, saw_ack, done_cnt);
        end
    endtask

    task automatic test_fifo_backpressure();
        logic [7:0] b [6] = '{8'h01, 8'h80, 8'h5A, 8'hC3, 8'h7E, 8'h99};
        bit ok;
        popped.delete(); ack_bits.delete(); out_ready = 1'b0;
        do_start(8'd6);
        for (int k = 0; k < 4; k++) begin
            serve_bits(b[k], 8, 1, 0, ok);
            n_checks++;
            if (!ok) begin n_fail++; $display("FAIL bp_rd_go[%0d]: got timeout expected rd_go", k); end
            serve_ack(ok);
        end
        saw_rd = 0;
        repeat (10) tick();
        n_checks++;
        if (saw_rd !== 1'b0 || busy !== 1'b1 || dut.u_fifo.count !== 3'd4 || out_byte !== b[0]) begin
            n_fail++;
            $display("FAIL bp_hold: got rd=%0b busy=%0b count=%0d head=%0h expected 0 1 4 %0h",
                     saw_rd, busy, dut.u_fifo.count, out_byte, b[0]);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        serve_bits(b[4], 8, 1, 1, ok);
        n_checks++;
        if (!ok || dut.u_fifo.count !== 3'd3 || popped.size() !== 2) begin
            n_fail++;
            $display("FAIL bp_push_pop: got ok=%0d count=%0d popped=%0d expected 1 3 2",
                     ok, dut.u_fifo.count, popped.size());
        end
        out_ready = 1'b1;
        serve_ack(ok);
        serve_bits(b[5], 8, 1, 0, ok);
        serve_ack(ok);
        wait_done(ok);
        repeat (8) tick();
        n_checks++;
        if (popped.size() !== 6 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_drain: got bytes=%0d valid=%0b expected 6 0", popped.size(), out_valid);
        end else begin
            for (int k = 0; k < 6; k++) begin
                n_checks++;
                if (popped[k] !== b[k]) begin
                    n_fail++;
                    $display("FAIL bp_byte[%0d]: got %0h expected %0h", k, popped[k], b[k]);
                end
            end
        end
        n_checks++;
        if (ack_bits.size() !== 6 || ack_bits[5] !== 1'b1 || ack_bits[4] !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_acks: got n=%0d expected 6 with NACK last", ack_bits.size());
        end
    endtask

    task automatic test_abort();
        logic [2:0] bits = 3'b101;
        bit ok;
        popped.delete(); done_cnt = 0; out_ready = 1'b0;
        do_start(8'd2);
        serve_bits(8'hD2, 8, 1, 0, ok);
        serve_ack(ok);
        ok = 0;
        for (int w = 0; w < 200 && !ok; w++) begin
            @(negedge clock);
            if (rd_go) ok = 1;
        end
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL abort_rd_go: got timeout expected rd_go"); end
        for (int i = 0; i < 3; i++) begin
            tick();
            rd_load = 1'b1;
            rd_data = bits[2-i];
        end
        tick();
        rd_load = 1'b0;
        rd_data = 1'b0;
        abort   = 1'b1;
        tick();
        abort = 1'b0;
        n_checks++;
        if ({rd_go, ack_go, done} !== 3'b001) begin
            n_fail++;
            $display("FAIL abort_next: got rd=%0b ack=%0b done=%0b expected 0 0 1", rd_go, ack_go, done);
        end
        tick();
        n_checks++;
        if (busy !== 1'b0 || done_cnt !== 1 || dut.u_fifo.count !== 3'd1 || out_byte !== 8'hD2) begin
            n_fail++;
            $display("FAIL abort_fifo: got busy=%0b dones=%0d count=%0d head=%0h expected 0 1 1 d2",
                     busy, done_cnt, dut.u_fifo.count, out_byte);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || popped.size() !== 1) begin
            n_fail++;
            $display("FAIL abort_drain: got valid=%0b popped=%0d expected 0 1", out_valid, popped.size());
        end
    endtask

    task automatic test_short_byte();
        bit ok;
        popped.delete(); ack_bits.delete(); out_ready = 1'b1;
        do_start(8'd1);
        serve_bits(8'h55, 7, 0, 0, ok);
        serve_ack(ok);
        wait_done(ok);
        tick();
        n_checks++;
        if (dut.err_len !== 1'b1 || popped.size() !== 1) begin
            n_fail++;
            $display("FAIL short_err: got err=%0b popped=%0d expected 1 1", dut.err_len, popped.size());
        end else begin
            n_checks++;
            if (popped[0] !== 8'h55) begin
                n_fail++;
                $display("FAIL short_byte: got %0h expected 55", popped[0]);
            end
        end
    endtask

    task automatic test_reset_mid_ack();
        bit ok;
        out_ready = 1'b0;
        do_start(8'd2);
        serve_bits(8'h6E, 8, 1, 0, ok);
        n_checks++;
        if (ack_go !== 1'b1 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pre: got ack_go=%0b valid=%0b expected 1 1", ack_go, out_valid);
        end
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, rd_go, ack_go, ack_bit, out_valid, out_byte, dut.u_fifo.count, dut.err_len} !== 18'h0) begin
            n_fail++;
            $display("FAIL rst_async: got %0h expected 0",
                     {busy, done, rd_go, ack_go, ack_bit, out_valid, out_byte, dut.u_fifo.count, dut.err_len});
        end
        tick();
        reset_n = 1'b1;
        popped.delete(); ack_bits.delete(); out_ready = 1'b1;
        do_start(8'd1);
        serve_bits(8'h42, 8, 1, 0, ok);
        serve_ack(ok);
        wait_done(ok);
        tick();
        n_checks++;
        if (!ok || busy !== 1'b0 || ack_bits.size() !== 1 || popped.size() !== 1) begin
            n_fail++;
            $display("FAIL rst_restart: got ok=%0d busy=%0b acks=%0d bytes=%0d expected 1 0 1 1",
                     ok, busy, ack_bits.size(), popped.size());
        end else begin
            n_checks++;
            if (ack_bits[0] !== 1'b1 || popped[0] !== 8'h42) begin
                n_fail++;
                $display("FAIL rst_restart_data: got %0b/%0h expected 1/42", ack_bits[0], popped[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_three_bytes();
        test_zero_length();
        test_fifo_backpressure();
        test_abort();
        test_short_byte();
        test_reset_mid_ack();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected summary before time limit");
        $fatal(1);
    end

endmodule
